// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO so that byte-strobe producers never stall.
// The TX line is registered. Bytes are sent LSB first, and there is one IDLE cycle between frames.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 8,
    parameter int ADDR_W       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_data_rdy,
    input  logic [7:0]        tx_data,
    output logic              uart_txd,
    output logic              tx_busy,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state, state_n;
    logic [BAUD_W-1:0]   baud, baud_n;
    logic [2:0]          bit_idx, bit_n;
    logic [7:0]          shift, shift_n;
    logic                txd_n;
    logic [7:0]          mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
    logic                push, pop;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FULL_CNT);
    assign tx_busy    = (state != IDLE);
    // Full is judged on the registered count, so a same-cycle pop cannot rescue a write.
    assign push       = tx_data_rdy && !fifo_full;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (tx_data_rdy && fifo_full) overflow <= 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_txd <= 1'b1;
        end else begin
            state    <= state_n;
            baud     <= baud_n;
            bit_idx  <= bit_n;
            shift    <= shift_n;
            uart_txd <= txd_n;
        end
    end

    // The line level is computed for the next state, so uart_txd changes on the same edge as the state.
    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_idx;
        shift_n = shift;
        txd_n   = uart_txd;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    state_n = START;
                    baud_n  = '0;
                    txd_n   = 1'b0;
                end
            end
            START: begin
                if (baud == BAUD_LAST) begin
                    state_n = DATA;
                    baud_n  = '0;
                    bit_n   = '0;
                    txd_n   = shift[0];
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        txd_n   = 1'b1;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                        txd_n = shift[bit_n];
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            STOP: begin
                if (baud == BAUD_LAST) begin
                    state_n = IDLE;
                    baud_n  = '0;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo. Each strobed byte is queued, and a line monitor decodes every
// 8N1 frame and compares it with the queue head.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_data_rdy = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       uart_txd, tx_busy, fifo_empty, fifo_full, overflow;
    logic [3:0] fifo_count;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         frames = 0;
    int         pushed = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];

    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .tx_data_rdy(tx_data_rdy), .tx_data(tx_data),
        .uart_txd(uart_txd), .tx_busy(tx_busy), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back(b);
        pushed++;
    endtask

    task automatic strobe(input logic [7:0] b);
        @(negedge clk);
        tx_data_rdy = 1'b1;
        tx_data = b;
        expect_byte(b);
        @(negedge clk);
        tx_data_rdy = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || tx_busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", (n < 2000), 1);
        @(negedge clk);
    endtask

    // The line is sampled mid-bit (2 cycles into each 4-cycle bit). A reset aborts the frame in progress.
    initial begin : monitor
        logic [7:0] rx;
        logic       ok;
        int         t0;
        forever begin
            @(negedge clk);
            if (rst && !uart_txd) begin
                ok = 1'b1;
                rx = 8'h00;
                t0 = cyc;
                repeat (2) begin @(negedge clk); if (!rst) ok = 1'b0; end
                if (ok) chk("start_bit", uart_txd, 0);
                for (int i = 0; i < 8 && ok; i++) begin
                    repeat (4) begin @(negedge clk); if (!rst) ok = 1'b0; end
                    rx[i] = uart_txd;
                end
                if (ok) begin
                    repeat (4) begin @(negedge clk); if (!rst) ok = 1'b0; end
                end
                if (ok) begin
                    chk("stop_bit", uart_txd, 1);
                    start_q.push_back(t0);
                    frames++;
                    if (exp_q.size() == 0) chk("unexpected_frame", {24'h0, rx}, 32'hFFFF_FFFF);
                    else chk("frame_byte", rx, exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n;
        int lows;
        // reset state
        #2 rst = 1'b0;
        #10;
        chk("rst_txd", uart_txd, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);

        // single 0x41 frame: latency and busy length
        strobe(8'h41);
        chk("t1_empty", fifo_empty, 0);
        chk("t1_count", fifo_count, 1);
        chk("t1_txd_idle", uart_txd, 1);
        @(negedge clk);
        chk("t1_txd_fall", uart_txd, 0);
        chk("t1_busy", tx_busy, 1);
        chk("t1_count_pop", fifo_count, 0);
        n = 1;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            if (!tx_busy) break;
            n++;
        end
        chk("t1_busy_cycles", n, 40);
        chk("t1_empty_end", fifo_empty, 1);
        wait_idle();

        // three back-to-back strobes
        start_q.delete();
        @(negedge clk); tx_data_rdy = 1'b1; tx_data = 8'h4C; expect_byte(8'h4C);
        @(negedge clk); chk("t2_count_a", fifo_count, 1); tx_data = 8'h41; expect_byte(8'h41);
        @(negedge clk); chk("t2_count_b", fifo_count, 1); tx_data = 8'h42; expect_byte(8'h42);
        @(negedge clk); tx_data_rdy = 1'b0;
        chk("t2_count_peak", fifo_count, 2);
        wait_idle();
        chk("t2_frames", start_q.size(), 3);
        if (start_q.size() == 3) begin
            chk("t2_period_1", start_q[1] - start_q[0], 41);
            chk("t2_period_2", start_q[2] - start_q[1], 41);
        end

        // overflow while busy
        strobe(8'h7E);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 8) begin
                chk("t3_count8", fifo_count, 8);
                chk("t3_full", fifo_full, 1);
                chk("t3_ovf_pre", overflow, 0);
            end
            tx_data_rdy = 1'b1;
            tx_data = 8'(8'h30 + i);
            if (i < 8) expect_byte(8'(8'h30 + i));
        end
        @(negedge clk); tx_data_rdy = 1'b0;
        chk("t3_ovf", overflow, 1);
        chk("t3_count_after", fifo_count, 8);
        wait_idle();
        chk("t3_ovf_sticky", overflow, 1);

        // write on a full FIFO in the pop cycle is still dropped
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            tx_data_rdy = 1'b1;
            tx_data = 8'(8'h11 + i);
            expect_byte(8'(8'h11 + i));
        end
        @(negedge clk); tx_data_rdy = 1'b0;
        chk("t4_fill", fifo_count, 8);
        n = 0;
        while (tx_busy && n < 100) begin @(negedge clk); n++; end
        chk("t4_reach_idle", (n < 100), 1);
        chk("t4_pre_count", fifo_count, 8);
        chk("t4_pre_ovf", overflow, 0);
        tx_data_rdy = 1'b1; tx_data = 8'hEE;
        @(negedge clk); tx_data_rdy = 1'b0;
        chk("t4_count7", fifo_count, 7);
        chk("t4_ovf", overflow, 1);
        chk("t4_not_full", fifo_full, 0);
        wait_idle();

        // asynchronous reset mid-frame
        strobe(8'h55);
        repeat (15) @(negedge clk);
        chk("t5_busy_before", tx_busy, 1);
        @(posedge clk); #2 rst = 1'b0; #1;
        chk("t5_txd", uart_txd, 1);
        chk("t5_busy", tx_busy, 0);
        chk("t5_empty", fifo_empty, 1);
        chk("t5_full", fifo_full, 0);
        chk("t5_count", fifo_count, 0);
        chk("t5_ovf", overflow, 0);
        exp_q.delete();
        pushed--;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        lows = 0;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            if (!uart_txd || tx_busy) lows++;
        end
        chk("t5_quiet", lows, 0);
        strobe(8'h0D);
        wait_idle();

        // paced traffic wraps the pointers
        for (int i = 0; i < 20; i++) begin
            strobe(8'(i * 37 + 5));
            wait_idle();
        end
        chk("t6_ovf", overflow, 0);
        chk("end_queue_empty", exp_q.size(), 0);
        chk("end_frames", frames, pushed);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
